// File: rtl/act_fifo_wc_pkg.sv
// act_fifo_pkg: shared types and elaboration helpers for the wide/narrow
// activation FIFO.
//   lanes()        - elements carried by a port of a given bit width
//   ptr_width()    - element pointer width for a given depth
//   params_legal() - parameter-set legality check used at elaboration
//   port_sel_e     - which port (if any) won write/read arbitration
package act_fifo_pkg;

  typedef enum logic [1:0] {
    PORT_NONE,
    PORT_EXT,
    PORT_INT
  } port_sel_e;

  function automatic int unsigned lanes(input int unsigned width,
                                        input int unsigned data_size);
    return width / data_size;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic bit params_legal(input int unsigned data_size,
                                      input int unsigned depth,
                                      input int unsigned ext_width,
                                      input int unsigned int_width);
    bit ok;
    ok = (data_size != 0) && (depth > 1) && ((depth & (depth - 1)) == 0);
    ok = ok && (ext_width != 0) && (ext_width % data_size == 0);
    ok = ok && (int_width % ext_width == 0);
    ok = ok && (depth % lanes(int_width, data_size) == 0);
    return ok;
  endfunction

endpackage

// File: rtl/act_fifo_wc_if.sv
// act_fifo_wc_if: push/pop handshake bundle of the activation FIFO.
//   ext_* : narrow bus-facing side (EXT_WIDTH bits per transfer)
//   int_* : wide array-facing side (INT_WIDTH bits per transfer)
//   master modport: the traffic source/sink; slave modport: the FIFO.
interface act_fifo_wc_if #(
  parameter int unsigned EXT_WIDTH = 32,
  parameter int unsigned INT_WIDTH = 256
);
  logic                 ext_wr_valid_i;
  logic                 ext_wr_ready_o;
  logic [EXT_WIDTH-1:0] ext_wr_data_i;
  logic                 ext_rd_req_i;
  logic                 ext_rd_ready_o;
  logic [EXT_WIDTH-1:0] ext_rd_data_o;
  logic                 ext_rd_valid_o;

  logic                 int_wr_valid_i;
  logic                 int_wr_ready_o;
  logic [INT_WIDTH-1:0] int_wr_data_i;
  logic                 int_rd_req_i;
  logic                 int_rd_ready_o;
  logic [INT_WIDTH-1:0] int_rd_data_o;
  logic                 int_rd_valid_o;

  modport master (
    output ext_wr_valid_i, ext_wr_data_i, ext_rd_req_i,
    output int_wr_valid_i, int_wr_data_i, int_rd_req_i,
    input  ext_wr_ready_o, ext_rd_ready_o, ext_rd_data_o, ext_rd_valid_o,
    input  int_wr_ready_o, int_rd_ready_o, int_rd_data_o, int_rd_valid_o
  );

  modport slave (
    input  ext_wr_valid_i, ext_wr_data_i, ext_rd_req_i,
    input  int_wr_valid_i, int_wr_data_i, int_rd_req_i,
    output ext_wr_ready_o, ext_rd_ready_o, ext_rd_data_o, ext_rd_valid_o,
    output int_wr_ready_o, int_rd_ready_o, int_rd_data_o, int_rd_valid_o
  );
endinterface

// File: rtl/act_fifo_wc_mem.sv
// act_fifo_mem: element-addressed circular storage.
//   wr_en/wr_addr/wr_lane_en/wr_data : lane k stored at (wr_addr + k) mod DEPTH
//   rd_en/rd_addr/rd_data            : lane k fetched from (rd_addr + k) mod DEPTH,
//                                      registered, held until the next rd_en
// Storage is not reset; only the read register is.
module act_fifo_mem
  import act_fifo_pkg::*;
#(
  parameter  int unsigned DATA_SIZE = 8,
  parameter  int unsigned DEPTH     = 1024,
  parameter  int unsigned LANES     = 32,
  localparam int unsigned PTR_W     = ptr_width(DEPTH)
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       wr_en,
  input  logic [PTR_W-1:0]           wr_addr,
  input  logic [LANES-1:0]           wr_lane_en,
  input  logic [LANES*DATA_SIZE-1:0] wr_data,
  input  logic                       rd_en,
  input  logic [PTR_W-1:0]           rd_addr,
  output logic [LANES*DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // Pointer-width addition wraps naturally at DEPTH (power of 2).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (wr_lane_en[k]) mem[wr_addr + PTR_W'(k)] <= wr_data[k*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        rd_data[k*DATA_SIZE +: DATA_SIZE] <= mem[rd_addr + PTR_W'(k)];
      end
    end
  end

endmodule

// File: rtl/act_fifo_wc.sv
// act_fifo_wc: circular activation buffer with a narrow external and a wide
// internal push/pop port sharing one element-granular pointer pair.
//   clk, nrst          : clock, asynchronous active-low reset
//   soft_clr_i         : synchronous flush of pointers and level
//   afull_thresh_i     : almost-full threshold in elements
//   bus (slave)        : ext/int valid-ready push and req-ready pop ports
//   level_o, empty_o, full_o, afull_o : occupancy view
//   head_o, tail_o     : write / read pointer snoop
module act_fifo_wc
  import act_fifo_pkg::*;
#(
  parameter  int unsigned DATA_SIZE = 8,
  parameter  int unsigned DEPTH     = 1024,
  parameter  int unsigned EXT_WIDTH = 32,
  parameter  int unsigned INT_WIDTH = 256,
  localparam int unsigned EXT_LANES = lanes(EXT_WIDTH, DATA_SIZE),
  localparam int unsigned INT_LANES = lanes(INT_WIDTH, DATA_SIZE),
  localparam int unsigned PTR_W     = ptr_width(DEPTH),
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             soft_clr_i,
  input  logic [CNT_W-1:0] afull_thresh_i,
  act_fifo_wc_if.slave     bus,
  output logic [CNT_W-1:0] level_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             afull_o,
  output logic [PTR_W-1:0] head_o,
  output logic [PTR_W-1:0] tail_o
);

  if (!params_legal(DATA_SIZE, DEPTH, EXT_WIDTH, INT_WIDTH)) begin : g_param_check
    $error("act_fifo_wc: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] EXT_C   = CNT_W'(EXT_LANES);
  localparam logic [CNT_W-1:0] INT_C   = CNT_W'(INT_LANES);

  logic [CNT_W-1:0]     level_q, free, wr_lanes, rd_lanes;
  logic [PTR_W-1:0]     head_q, tail_q;
  logic                 ext_rd_valid_q, int_rd_valid_q;
  logic [EXT_WIDTH-1:0] ext_hold_q;
  logic [INT_WIDTH-1:0] int_hold_q;
  logic                 int_wr_rdy, ext_wr_rdy, int_rd_rdy, ext_rd_rdy;
  port_sel_e            wr_sel, rd_sel;
  logic [INT_LANES-1:0] wr_lane_en;
  logic [INT_WIDTH-1:0] wr_data, rd_data;

  // Readies depend on registered level only (no write-to-read bypass) and
  // are forced low while reset is asserted.
  always_comb begin
    free       = DEPTH_C - level_q;
    int_wr_rdy = nrst && !soft_clr_i && (free >= INT_C);
    ext_wr_rdy = nrst && !soft_clr_i && !bus.int_wr_valid_i && (free >= EXT_C);
    int_rd_rdy = nrst && !soft_clr_i && (level_q >= INT_C);
    ext_rd_rdy = nrst && !soft_clr_i && !bus.int_rd_req_i && (level_q >= EXT_C);

    wr_sel     = PORT_NONE;
    wr_lanes   = '0;
    wr_data    = '0;
    wr_lane_en = '0;
    if (bus.int_wr_valid_i && int_wr_rdy) begin
      wr_sel     = PORT_INT;
      wr_lanes   = INT_C;
      wr_data    = bus.int_wr_data_i;
      wr_lane_en = '1;
    end else if (bus.ext_wr_valid_i && ext_wr_rdy) begin
      wr_sel     = PORT_EXT;
      wr_lanes   = EXT_C;
      wr_data    = INT_WIDTH'(bus.ext_wr_data_i);
      wr_lane_en = INT_LANES'({EXT_LANES{1'b1}});
    end

    rd_sel   = PORT_NONE;
    rd_lanes = '0;
    if (bus.int_rd_req_i && int_rd_rdy) begin
      rd_sel   = PORT_INT;
      rd_lanes = INT_C;
    end else if (bus.ext_rd_req_i && ext_rd_rdy) begin
      rd_sel   = PORT_EXT;
      rd_lanes = EXT_C;
    end
  end

  // Read-valid flags are not touched by soft clear so a pop accepted just
  // before the clear still delivers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      level_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      ext_rd_valid_q <= 1'b0;
      int_rd_valid_q <= 1'b0;
    end else begin
      ext_rd_valid_q <= (rd_sel == PORT_EXT);
      int_rd_valid_q <= (rd_sel == PORT_INT);
      if (soft_clr_i) begin
        level_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        level_q <= level_q + wr_lanes - rd_lanes;
        head_q  <= head_q + PTR_W'(wr_lanes);
        tail_q  <= tail_q + PTR_W'(rd_lanes);
      end
    end
  end

  // The storage read register is shared by both ports; each port keeps its
  // own copy of its last word so data holds across the other port's pops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ext_hold_q <= '0;
      int_hold_q <= '0;
    end else begin
      if (ext_rd_valid_q) ext_hold_q <= rd_data[EXT_WIDTH-1:0];
      if (int_rd_valid_q) int_hold_q <= rd_data;
    end
  end

  act_fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .LANES     (INT_LANES)
  ) u_mem (
    .clk        (clk),
    .nrst       (nrst),
    .wr_en      (wr_sel != PORT_NONE),
    .wr_addr    (head_q),
    .wr_lane_en (wr_lane_en),
    .wr_data    (wr_data),
    .rd_en      (rd_sel != PORT_NONE),
    .rd_addr    (tail_q),
    .rd_data    (rd_data)
  );

  assign bus.int_wr_ready_o = int_wr_rdy;
  assign bus.ext_wr_ready_o = ext_wr_rdy;
  assign bus.int_rd_ready_o = int_rd_rdy;
  assign bus.ext_rd_ready_o = ext_rd_rdy;
  assign bus.ext_rd_valid_o = ext_rd_valid_q;
  assign bus.int_rd_valid_o = int_rd_valid_q;
  assign bus.ext_rd_data_o  = ext_rd_valid_q ? rd_data[EXT_WIDTH-1:0] : ext_hold_q;
  assign bus.int_rd_data_o  = int_rd_valid_q ? rd_data : int_hold_q;

  assign level_o = level_q;
  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == DEPTH_C);
  assign afull_o = (level_q >= afull_thresh_i);
  assign head_o  = head_q;
  assign tail_o  = tail_q;

endmodule

// File: tb/tb_act_fifo_wc.sv
// tb_act_fifo_wc: directed plus randomized checks of act_fifo_wc (DEPTH=64)
// against an element-queue reference model.
module tb_act_fifo_wc;
  localparam int unsigned DS    = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned EW    = 32;
  localparam int unsigned IW    = 256;
  localparam int unsigned EL    = EW / DS;
  localparam int unsigned IL    = IW / DS;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned PW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          soft_clr = 1'b0;
  logic [CW-1:0] thresh;
  logic [CW-1:0] level;
  logic          empty, full, afull;
  logic [PW-1:0] head, tail;

  act_fifo_wc_if #(.EXT_WIDTH(EW), .INT_WIDTH(IW)) bus ();

  act_fifo_wc #(
    .DATA_SIZE (DS),
    .DEPTH     (DEPTH),
    .EXT_WIDTH (EW),
    .INT_WIDTH (IW)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .soft_clr_i     (soft_clr),
    .afull_thresh_i (thresh),
    .bus            (bus),
    .level_o        (level),
    .empty_o        (empty),
    .full_o         (full),
    .afull_o        (afull),
    .head_o         (head),
    .tail_o         (tail)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is a queue of elements; pointers are counts mod DEPTH.
  logic [7:0]    q[$];
  int unsigned   m_head, m_tail;
  logic [EW-1:0] m_ext_data;
  logic [IW-1:0] m_int_data;
  logic          m_ext_v, m_int_v;

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_head = 0;
    m_tail = 0;
    m_ext_data = '0;
    m_int_data = '0;
    m_ext_v = 1'b0;
    m_int_v = 1'b0;
  endtask

  task automatic idle();
    bus.ext_wr_valid_i = 1'b0;
    bus.ext_rd_req_i   = 1'b0;
    bus.int_wr_valid_i = 1'b0;
    bus.int_rd_req_i   = 1'b0;
  endtask

  task automatic push_model(input logic [IW-1:0] w, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) q.push_back(w[8*k +: 8]);
    m_head = (m_head + n) % DEPTH;
  endtask

  // One clock: check readies for the current inputs, advance the model on
  // the edge, then check every state output.
  task automatic cycle();
    bit          e_iwr, e_ewr, e_ird, e_erd;
    int unsigned lvl;
    #1;
    lvl   = q.size();
    e_iwr = (DEPTH - lvl >= IL) && !soft_clr;
    e_ewr = (DEPTH - lvl >= EL) && !soft_clr && !bus.int_wr_valid_i;
    e_ird = (lvl >= IL) && !soft_clr;
    e_erd = (lvl >= EL) && !soft_clr && !bus.int_rd_req_i;
    chk("int_wr_ready", IW'(bus.int_wr_ready_o), IW'(e_iwr));
    chk("ext_wr_ready", IW'(bus.ext_wr_ready_o), IW'(e_ewr));
    chk("int_rd_ready", IW'(bus.int_rd_ready_o), IW'(e_ird));
    chk("ext_rd_ready", IW'(bus.ext_rd_ready_o), IW'(e_erd));
    @(posedge clk);
    #1;
    m_int_v = 1'b0;
    m_ext_v = 1'b0;
    if (soft_clr) begin
      q.delete();
      m_head = 0;
      m_tail = 0;
    end else begin
      if (e_ird && bus.int_rd_req_i) begin
        for (int unsigned k = 0; k < IL; k++) m_int_data[8*k +: 8] = q.pop_front();
        m_int_v = 1'b1;
        m_tail  = (m_tail + IL) % DEPTH;
      end else if (e_erd && bus.ext_rd_req_i) begin
        for (int unsigned k = 0; k < EL; k++) m_ext_data[8*k +: 8] = q.pop_front();
        m_ext_v = 1'b1;
        m_tail  = (m_tail + EL) % DEPTH;
      end
      if (e_iwr && bus.int_wr_valid_i) push_model(bus.int_wr_data_i, IL);
      else if (e_ewr && bus.ext_wr_valid_i) push_model(IW'(bus.ext_wr_data_i), EL);
    end
    chk("level", IW'(level), IW'(q.size()));
    chk("empty", IW'(empty), IW'(q.size() == 0));
    chk("full", IW'(full), IW'(q.size() == DEPTH));
    chk("afull", IW'(afull), IW'(q.size() >= int'(thresh)));
    chk("head", IW'(head), IW'(m_head));
    chk("tail", IW'(tail), IW'(m_tail));
    chk("int_rd_valid", IW'(bus.int_rd_valid_o), IW'(m_int_v));
    chk("ext_rd_valid", IW'(bus.ext_rd_valid_o), IW'(m_ext_v));
    chk("int_rd_data", bus.int_rd_data_o, m_int_data);
    chk("ext_rd_data", IW'(bus.ext_rd_data_o), IW'(m_ext_data));
  endtask

  task automatic ext_push(input logic [EW-1:0] w);
    bus.ext_wr_valid_i = 1'b1;
    bus.ext_wr_data_i  = w;
    cycle();
    bus.ext_wr_valid_i = 1'b0;
  endtask

  task automatic int_push(input logic [IW-1:0] w);
    bus.int_wr_valid_i = 1'b1;
    bus.int_wr_data_i  = w;
    cycle();
    bus.int_wr_valid_i = 1'b0;
  endtask

  task automatic ext_pop();
    bus.ext_rd_req_i = 1'b1;
    cycle();
    bus.ext_rd_req_i = 1'b0;
  endtask

  task automatic int_pop();
    bus.int_rd_req_i = 1'b1;
    cycle();
    bus.int_rd_req_i = 1'b0;
  endtask

  logic [IW-1:0] exp_w;
  logic [EW-1:0] exp_e;

  initial begin
    idle();
    bus.ext_wr_data_i = '0;
    bus.int_wr_data_i = '0;
    thresh = CW'(0);
    model_reset();

    // Reset values, including afull with a zero threshold.
    #3;
    chk("rst_int_wr_ready", IW'(bus.int_wr_ready_o), '0);
    chk("rst_ext_wr_ready", IW'(bus.ext_wr_ready_o), '0);
    chk("rst_int_rd_ready", IW'(bus.int_rd_ready_o), '0);
    chk("rst_int_rd_valid", IW'(bus.int_rd_valid_o), '0);
    chk("rst_int_rd_data", bus.int_rd_data_o, '0);
    chk("rst_empty", IW'(empty), IW'(1));
    chk("rst_full", IW'(full), '0);
    chk("rst_afull_thr0", IW'(afull), IW'(1));
    thresh = CW'(40);
    #1;
    chk("rst_afull_thr40", IW'(afull), '0);
    @(negedge clk);
    nrst = 1'b1;

    // 8 narrow pushes of 0x00..0x1F, one wide pop.
    for (int unsigned i = 0; i < 8; i++) begin
      exp_e = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      ext_push(exp_e);
    end
    chk("tp1_level32", IW'(level), IW'(32));
    int_pop();
    for (int unsigned k = 0; k < IL; k++) exp_w[8*k +: 8] = 8'(k);
    chk("tp1_int_data", bus.int_rd_data_o, exp_w);
    chk("tp1_int_valid", IW'(bus.int_rd_valid_o), IW'(1));
    chk("tp1_empty", IW'(empty), IW'(1));

    // One wide push of 0xA0..0xBF, 8 narrow pops.
    for (int unsigned k = 0; k < IL; k++) exp_w[8*k +: 8] = 8'(8'hA0 + k);
    int_push(exp_w);
    for (int unsigned i = 0; i < 8; i++) begin
      ext_pop();
      exp_e = {8'(8'hA3 + 4*i), 8'(8'hA2 + 4*i), 8'(8'hA1 + 4*i), 8'(8'hA0 + 4*i)};
      chk("tp2_ext_word", IW'(bus.ext_rd_data_o), IW'(exp_e));
    end

    // Fill to 60, wide push refused, one narrow push fills completely.
    for (int unsigned i = 0; i < 15; i++) ext_push($urandom);
    bus.int_wr_valid_i = 1'b1;
    bus.int_wr_data_i  = {8{$urandom}};
    cycle();
    bus.int_wr_valid_i = 1'b0;
    ext_push($urandom);
    #1;
    chk("tp3_full", IW'(full), IW'(1));
    chk("tp3_ext_wr_ready", IW'(bus.ext_wr_ready_o), '0);
    int_pop();
    int_pop();

    // Wrap: move both pointers to 60, then a wide push/pop straddles 63->0.
    for (int unsigned i = 0; i < 15; i++) ext_push($urandom);
    for (int unsigned i = 0; i < 15; i++) ext_pop();
    chk("tp4_head60", IW'(head), IW'(60));
    exp_w = {8{$urandom}};
    int_push(exp_w);
    chk("tp4_head28", IW'(head), IW'(28));
    int_pop();
    chk("tp4_wrap_data", bus.int_rd_data_o, exp_w);

    // Same-cycle arbitration: internal wins on both sides.
    bus.int_wr_valid_i = 1'b1;
    bus.ext_wr_valid_i = 1'b1;
    bus.int_wr_data_i  = {8{$urandom}};
    bus.ext_wr_data_i  = $urandom;
    cycle();
    idle();
    chk("tp5_level32", IW'(level), IW'(32));
    bus.int_rd_req_i = 1'b1;
    bus.ext_rd_req_i = 1'b1;
    cycle();
    idle();
    chk("tp5_level0", IW'(level), '0);
    chk("tp5_ext_valid", IW'(bus.ext_rd_valid_o), '0);

    // Almost-full, soft clear, then reset mid-read.
    int_push({8{$urandom}});
    ext_push($urandom);
    chk("tp6_afull36", IW'(afull), '0);
    ext_push($urandom);
    chk("tp6_afull40", IW'(afull), IW'(1));
    soft_clr = 1'b1;
    cycle();
    soft_clr = 1'b0;
    chk("tp6_clr_level", IW'(level), '0);
    chk("tp6_clr_head", IW'(head), '0);
    chk("tp6_clr_tail", IW'(tail), '0);
    chk("tp6_clr_empty", IW'(empty), IW'(1));
    chk("tp6_clr_afull", IW'(afull), '0);
    for (int unsigned i = 0; i < 8; i++) ext_push($urandom);
    int_pop();
    chk("tp6_pre_rst_valid", IW'(bus.int_rd_valid_o), IW'(1));
    nrst = 1'b0;
    #1;
    chk("tp6_rst_valid", IW'(bus.int_rd_valid_o), '0);
    chk("tp6_rst_level", IW'(level), '0);
    chk("tp6_rst_data", bus.int_rd_data_o, '0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;

    // Randomized traffic in alternating fill-heavy / drain-heavy phases.
    for (int unsigned i = 0; i < 600; i++) begin
      bit fill;
      fill = ((i / 75) % 2) == 0;
      bus.int_wr_valid_i = ($urandom_range(0, 99) < (fill ? 30 : 8));
      bus.ext_wr_valid_i = ($urandom_range(0, 99) < (fill ? 70 : 30));
      bus.int_rd_req_i   = ($urandom_range(0, 99) < (fill ? 8 : 30));
      bus.ext_rd_req_i   = ($urandom_range(0, 99) < (fill ? 30 : 70));
      bus.int_wr_data_i  = {8{$urandom}};
      bus.ext_wr_data_i  = $urandom;
      soft_clr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) thresh = CW'($urandom_range(0, DEPTH));
      cycle();
    end
    idle();
    soft_clr = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
